melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Alarm-melody controller for the egg timer.
- Steps a square-wave tone generator through a fixed note table. Drives the generator's 16-bit half-period divider and its active-high reset.
- Plays each note for a programmed duration, then inserts a silent gap. Repeats the whole melody a fixed number of times.
- Started by the timer-expiry logic; can be aborted by the user at any point.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1000, duration time base (1 ms tick).
- NUM_NOTES, 8, entries in the note table (max 16).
- GAP_TICKS, 20, silent ticks between notes.
- REPEATS, 3, number of complete melody passes (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin the melody.
- stop  in  1  abort request, level or pulse.
- busy  out  1  high from LOAD through the DONE state.
- done  out  1  one-cycle pulse on natural completion.
- clk_divider  out  16  half-period count to the tone generator.
- tone_reset  out  1  active-high; holds the tone generator silent.
- note_idx  out  4  index of the current note.

Behaviour:
- Interface:
  - One clock.
  - reset is synchronous and active-low.
  - Ports are named clk and reset.
- Reset values (reset==0 at posedge): clk_divider=0, tone_reset=1, busy=0, done=0, note_idx=0, pass counter=0, state=IDLE, tick prescaler=0.
- Tick:
  - Prescaler counts 0..TICK_CYC-1, where TICK_CYC=CLK_HZ/TICK_HZ (integer division, must be >=1).
  - The terminal count is one tick.
  - The prescaler and tick counter clear on every state entry, so durations are exact.
- Note table entry: {divider[15:0], dur_ticks[11:0]}.
  - divider==0 is a rest: tone_reset stays 1 during PLAY.
  - dur_ticks==0 is treated as 1.
- States: IDLE, LOAD, PLAY, GAP, DONE.
  - IDLE:
    - tone_reset=1, busy=0.
    - start=1 and stop=0 -> LOAD, with note_idx=0 and pass=0.
  - LOAD (1 cycle):
    - clk_divider <= table[note_idx].divider.
    - Tick counter loaded with the duration.
    - -> PLAY.
  - PLAY:
    - tone_reset=(divider==0).
    - Stays exactly dur_ticks*TICK_CYC cycles -> GAP.
  - GAP:
    - tone_reset=1; clk_divider holds its value.
    - Stays exactly GAP_TICKS*TICK_CYC cycles.
    - Then, if note_idx<NUM_NOTES-1: note_idx+1 -> LOAD.
    - Else if pass<REPEATS-1: pass+1, note_idx=0 -> LOAD.
    - Else -> DONE.
  - DONE (1 cycle): done=1, tone_reset=1 -> IDLE.
- Latency: start sampled at cycle N -> LOAD at N+1 -> tone_reset falls at N+2 (first note non-rest).
- Boundary conditions:
  - stop=1 in LOAD/PLAY/GAP/DONE -> IDLE next cycle. tone_reset=1 next cycle, no done pulse, note_idx cleared.
  - stop and start together in IDLE: stop wins.
  - start while busy is ignored (no restart).
  - A reset assertion mid-melody returns all outputs to reset values on the next edge.
  - A stop in the DONE cycle still completes the done pulse (done already asserted that cycle) and returns to IDLE.
- Arithmetic:
  - Tick counter is 12 bits; prescaler is $clog2(TICK_CYC) bits, minimum 1.
  - No wrap: counters compare against terminal values and reload on state change.

Decomposition:
- Package melody_pkg:
  - state enum;
  - note entry field widths;
  - note table constant (default melody of 8 notes, including one rest);
  - GAP/duration defaults.
- One sub-module, tick_prescaler: enable-less divider with sync clear and a one-cycle tick output.
- Note table is a constant case ROM in the package function note_lookup(idx).

Test Plan (CLK_HZ=1000, TICK_HZ=100 -> TICK_CYC=10, GAP_TICKS=2, REPEATS=2; table note0={500,3}, note3={0,1} rest):
- Reset held low 3 cycles, then released -> tone_reset=1, busy=0, clk_divider=0, done=0.
- start pulse at cycle 0:
  - busy=1 at cycle 1;
  - clk_divider=500 and tone_reset=0 at cycle 2;
  - tone_reset=1 at cycle 32;
  - next LOAD at cycle 52.
- Full run -> note_idx sequences 0..7 twice, then exactly one done pulse, busy=0 the cycle after DONE; total cycle count matches the table sum.
- Rest note (idx 3) -> tone_reset stays 1 through its 10-cycle PLAY; clk_divider=0.
- stop asserted during PLAY of note 2, pass 1 -> IDLE next cycle, tone_reset=1, note_idx=0, no done pulse ever.
- start together with stop in IDLE -> stays IDLE. start during PLAY -> no effect on note_idx or timing.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared definitions for the egg-timer alarm melody sequencer:
// FSM state codes, note-table field widths, default timing and the note ROM.
package melody_pkg;

  localparam int unsigned DIV_W   = 16;
  localparam int unsigned DUR_W   = 12;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] S_PLAY = 3'd2;
  localparam logic [STATE_W-1:0] S_GAP  = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE = 3'd4;

  localparam int unsigned DEF_NUM_NOTES = 8;
  localparam int unsigned DEF_GAP_TICKS = 20;
  localparam int unsigned DEF_REPEATS   = 3;

  typedef struct packed {
    logic [DIV_W-1:0] divider;
    logic [DUR_W-1:0] dur_ticks;
  } note_t;

  // Default melody; divider 0 is a rest, dur_ticks 0 plays as one tick.
  function automatic note_t note_lookup(input logic [IDX_W-1:0] idx);
    note_t n;
    case (idx)
      4'd0:    n = '{divider: 16'd500, dur_ticks: 12'd3};
      4'd1:    n = '{divider: 16'd450, dur_ticks: 12'd2};
      4'd2:    n = '{divider: 16'd400, dur_ticks: 12'd4};
      4'd3:    n = '{divider: 16'd0,   dur_ticks: 12'd1};
      4'd4:    n = '{divider: 16'd380, dur_ticks: 12'd2};
      4'd5:    n = '{divider: 16'd340, dur_ticks: 12'd0};
      4'd6:    n = '{divider: 16'd300, dur_ticks: 12'd2};
      4'd7:    n = '{divider: 16'd250, dur_ticks: 12'd5};
      default: n = '{divider: 16'd0,   dur_ticks: 12'd1};
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_CYC cycles.
// Ports: clk, reset (sync, active-low), clr (sync restart of the count),
//        tick_c (combinational, high on the terminal count).
module tick_prescaler #(
  parameter int unsigned TICK_CYC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(TICK_CYC - 1));

  // Count 0..TICK_CYC-1; clr restarts so the first tick lands TICK_CYC cycles later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Alarm-melody controller: walks the note ROM, drives the tone generator's
// half-period divider and silencing reset, inserts gaps, repeats the melody.
// Ports: clk, reset (sync, active-low), start (begin pulse), stop (abort),
//        busy, done (completion pulse), clk_divider[15:0], tone_reset, note_idx[3:0].
module melody_sequencer #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned NUM_NOTES = 8,
  parameter int unsigned GAP_TICKS = 20,
  parameter int unsigned REPEATS   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        done,
  output logic [15:0] clk_divider,
  output logic        tone_reset,
  output logic [3:0]  note_idx
);

  import melody_pkg::*;

  localparam int unsigned TICK_CYC_RAW = CLK_HZ / TICK_HZ;
  localparam int unsigned TICK_CYC     = (TICK_CYC_RAW == 0) ? 1 : TICK_CYC_RAW;
  localparam int unsigned PASS_W       = (REPEATS > 1) ? $clog2(REPEATS) : 1;
  localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'((GAP_TICKS == 0) ? 1 : GAP_TICKS);

  logic [STATE_W-1:0] state, state_nxt;
  logic [IDX_W-1:0]   note_nxt;
  logic [PASS_W-1:0]  pass_cnt, pass_nxt;
  logic [DUR_W-1:0]   tick_cnt, tick_nxt, dur_eff;
  logic [DIV_W-1:0]   div_nxt;
  logic               busy_nxt, done_nxt, tone_reset_nxt;
  logic               tick_c, last_tick, presc_clr_c;
  note_t              cur_note;

  tick_prescaler #(.TICK_CYC(TICK_CYC)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clr    (presc_clr_c),
    .tick_c (tick_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      note_idx    <= '0;
      pass_cnt    <= '0;
      tick_cnt    <= '0;
      clk_divider <= '0;
      tone_reset  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      note_idx    <= note_nxt;
      pass_cnt    <= pass_nxt;
      tick_cnt    <= tick_nxt;
      clk_divider <= div_nxt;
      tone_reset  <= tone_reset_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  // Next state, counters and next output values.
  always_comb begin
    state_nxt = state;
    note_nxt  = note_idx;
    pass_nxt  = pass_cnt;
    tick_nxt  = tick_cnt;
    div_nxt   = clk_divider;
    cur_note  = note_lookup(note_idx);
    dur_eff   = (cur_note.dur_ticks == '0) ? DUR_W'(1) : cur_note.dur_ticks;
    last_tick = tick_c && (tick_cnt <= DUR_W'(1));

    if (stop && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state_nxt = S_LOAD;
            note_nxt  = '0;
            pass_nxt  = '0;
          end
        end
        S_LOAD: begin
          div_nxt   = cur_note.divider;
          tick_nxt  = dur_eff;
          state_nxt = S_PLAY;
        end
        S_PLAY: begin
          if (last_tick) begin
            tick_nxt  = GAP_LOAD;
            state_nxt = S_GAP;
          end else if (tick_c) begin
            tick_nxt = tick_cnt - DUR_W'(1);
          end
        end
        S_GAP: begin
          if (last_tick) begin
            if (note_idx < IDX_W'(NUM_NOTES - 1)) begin
              note_nxt  = note_idx + IDX_W'(1);
              state_nxt = S_LOAD;
            end else if (pass_cnt < PASS_W'(REPEATS - 1)) begin
              pass_nxt  = pass_cnt + PASS_W'(1);
              note_nxt  = '0;
              state_nxt = S_LOAD;
            end else begin
              state_nxt = S_DONE;
            end
          end else if (tick_c) begin
            tick_nxt = tick_cnt - DUR_W'(1);
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end

    if (state_nxt == S_IDLE) note_nxt = '0;

    busy_nxt       = (state_nxt != S_IDLE);
    done_nxt       = (state_nxt == S_DONE);
    tone_reset_nxt = !((state_nxt == S_PLAY) && (div_nxt != '0));
    // Restart the tick base on every state entry so each phase is exact.
    presc_clr_c    = (state_nxt != state);
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed vector table,
// hand-written multi-cycle sequences, then random stimulus against a
// timeline-based reference model.
module tb_melody_sequencer;

  localparam int T_CYC   = 10;
  localparam int T_GAP   = 2;
  localparam int T_REP   = 2;
  localparam int T_NOTES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, tone_reset;
  logic [15:0] clk_divider;
  logic [3:0]  note_idx;

  melody_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .NUM_NOTES(8), .GAP_TICKS(2), .REPEATS(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .busy(busy), .done(done), .clk_divider(clk_divider),
    .tone_reset(tone_reset), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        tr;
    logic [3:0]  idx;
    logic [15:0] div;
  } out_t;

  typedef struct {
    logic tr;
    logic dn;
    int   note;
    int   div;   // -1: divider output holds its previous value
  } tl_t;

  typedef struct {
    logic  rst;
    logic  st;
    logic  sp;
    int    hold;
    out_t  exp;
    string name;
  } vec_t;

  int tb_div[8] = '{500, 450, 400, 0, 380, 340, 300, 250};
  int tb_dur[8] = '{3, 2, 4, 1, 2, 0, 2, 5};

  tl_t         tl[$];
  int          m_pos = -1;
  logic [15:0] m_div = 16'd0;
  int          n_pass = 0;
  int          n_chk = 0;
  vec_t        vecs[10];

  function automatic int dur_eff(input int n);
    return (tb_dur[n] == 0) ? 1 : tb_dur[n];
  endfunction

  // Expected per-cycle picture of one whole uninterrupted melody.
  function automatic void build_timeline();
    tl.delete();
    for (int p = 0; p < T_REP; p++) begin
      for (int n = 0; n < T_NOTES; n++) begin
        tl.push_back('{1'b1, 1'b0, n, -1});
        for (int c = 0; c < dur_eff(n) * T_CYC; c++)
          tl.push_back('{(tb_div[n] == 0), 1'b0, n, tb_div[n]});
        for (int c = 0; c < T_GAP * T_CYC; c++)
          tl.push_back('{1'b1, 1'b0, n, -1});
      end
    end
    tl.push_back('{1'b1, 1'b1, T_NOTES - 1, -1});
  endfunction

  function automatic void model_step(input logic r, input logic s, input logic p);
    if (!r) begin
      m_pos = -1;
      m_div = 16'd0;
    end else if (m_pos < 0) begin
      if (s && !p) m_pos = 0;
    end else if (p) begin
      m_pos = -1;
    end else begin
      m_pos++;
      if (m_pos >= tl.size()) m_pos = -1;
    end
    if (m_pos >= 0 && tl[m_pos].div >= 0) m_div = 16'(tl[m_pos].div);
  endfunction

  function automatic out_t model_out();
    if (m_pos < 0) return '{1'b0, 1'b0, 1'b1, 4'd0, m_div};
    return '{1'b1, tl[m_pos].dn, tl[m_pos].tr, 4'(tl[m_pos].note), m_div};
  endfunction

  function automatic out_t got();
    return '{busy, done, tone_reset, note_idx, clk_divider};
  endfunction

  task automatic check(input string name, input out_t g, input out_t e);
    n_chk++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got busy=%0b done=%0b tone_reset=%0b note_idx=%0d clk_divider=%0d, want busy=%0b done=%0b tone_reset=%0b note_idx=%0d clk_divider=%0d",
                  name, g.busy, g.done, g.tr, g.idx, g.div, e.busy, e.done, e.tr, e.idx, e.div);
  endtask

  task automatic check_int(input string name, input int g, input int e);
    n_chk++;
    if (g == e) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, g, e);
  endtask

  task automatic cycle(input logic r, input logic s, input logic p);
    reset = r; start = s; stop = p;
    @(posedge clk);
    model_step(r, s, p);
    #1;
  endtask

  initial begin
    int   nlog[$];
    int   done_cnt, done_cyc, rest_ok, rest_bad, errs, exp_total, hits, fired;
    logic prev, cur;
    logic [3:0] last_idx;

    build_timeline();

    // {reset, start, stop, extra hold cycles, expected {busy,done,tr,idx,div}, name}
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2,  '{1'b0, 1'b0, 1'b1, 4'd0, 16'd0},   "reset_values"};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 0,  '{1'b0, 1'b0, 1'b1, 4'd0, 16'd0},   "start_and_stop_idle"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 0,  '{1'b1, 1'b0, 1'b1, 4'd0, 16'd0},   "load_cycle1"};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 0,  '{1'b1, 1'b0, 1'b0, 4'd0, 16'd500}, "play_cycle2"};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 28, '{1'b1, 1'b0, 1'b0, 4'd0, 16'd500}, "play_last_cycle31"};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 0,  '{1'b1, 1'b0, 1'b1, 4'd0, 16'd500}, "gap_cycle32"};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 18, '{1'b1, 1'b0, 1'b1, 4'd0, 16'd500}, "gap_end_start_ignored"};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 0,  '{1'b1, 1'b0, 1'b1, 4'd1, 16'd500}, "load_note1_cycle52"};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 0,  '{1'b1, 1'b0, 1'b0, 4'd1, 16'd450}, "play_note1"};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 0,  '{1'b0, 1'b0, 1'b1, 4'd0, 16'd450}, "stop_in_play"};

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].rst, vecs[i].st, vecs[i].sp);
      for (int h = 0; h < vecs[i].hold; h++) cycle(vecs[i].rst, 1'b0, 1'b0);
      check(vecs[i].name, got(), vecs[i].exp);
    end

    // Full uninterrupted run with a stray start in the first note.
    exp_total = 0;
    for (int n = 0; n < T_NOTES; n++) exp_total += 1 + dur_eff(n) * T_CYC + T_GAP * T_CYC;
    exp_total = exp_total * T_REP + 1;
    cycle(1'b1, 1'b1, 1'b0);
    nlog.delete();
    nlog.push_back(int'(note_idx));
    last_idx = note_idx;
    done_cnt = 0; done_cyc = -1; rest_ok = 0; rest_bad = 0;
    for (int c = 2; c <= 900; c++) begin
      cycle(1'b1, (c == 10), 1'b0);
      if (busy && note_idx != last_idx) begin
        nlog.push_back(int'(note_idx));
        last_idx = note_idx;
      end
      if (busy && note_idx == 4'd3) begin
        if (!tone_reset) rest_bad++;
        else if (clk_divider == 16'd0) rest_ok++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cyc > 0 && c == done_cyc + 1) check_int("busy_after_done", int'(busy), 0);
    end
    check_int("done_pulses", done_cnt, 1);
    check_int("done_cycle", done_cyc, exp_total);
    check_int("note_log_len", nlog.size(), T_REP * T_NOTES);
    errs = 0;
    for (int i = 0; i < nlog.size(); i++) if (nlog[i] != i % T_NOTES) errs++;
    check_int("note_order_errs", errs, 0);
    check_int("rest_tone_on_cycles", rest_bad, 0);
    check_int("rest_silent_cycles", rest_ok, T_REP * (1 * T_CYC + T_GAP * T_CYC));

    // Abort during PLAY of note 2 in the second pass.
    cycle(1'b1, 1'b1, 1'b0);
    hits = 0; prev = 1'b0; fired = 0;
    for (int c = 0; c < 1000 && fired == 0; c++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cur = busy && (note_idx == 4'd2) && !tone_reset;
      if (cur && !prev) hits++;
      prev = cur;
      if (hits == 2) begin
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        check("stop_note2_pass1", got(), '{1'b0, 1'b0, 1'b1, 4'd0, 16'd400});
        fired = 1;
      end
    end
    check_int("stop_point_reached", fired, 1);
    done_cnt = 0;
    repeat (800) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (done || busy) done_cnt++;
    end
    check_int("quiet_after_stop", done_cnt, 0);

    // Reset mid-melody.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (100) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("reset_mid_melody", got(), '{1'b0, 1'b0, 1'b1, 4'd0, 16'd0});

    // Random start/stop/reset against the reference model.
    for (int i = 0; i < 8000; i++) begin
      cycle(($urandom_range(0, 4999) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 1499) == 0));
      check("rand", got(), model_out());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
